race_controller: RTL
====================

Name: race_controller

Overview:
- Top-level race sequencer. Generates the 3-bit `state` consumed by both player physics engines (3'd4 = racing).
- Runs the start countdown and issues a one-cycle physics reset so both cars return to their start positions.
- Consumes each car's `pos_x`/`pos_y` to count checkpoint-validated laps, time the race and declare a winner.

Parameters:
- CLK_FREQ, 100_000_000, system clock in Hz; TICK_LIMIT = CLK_FREQ/60 (60 Hz game tick).
- COUNT_TICKS, 60, game ticks per countdown digit.
- LAPS, 3, laps needed to finish (1..7).
- CP_X, 10'd240, checkpoint: pos_x >= CP_X arms the lap.
- FIN_X, 10'd40, finish zone: pos_x < FIN_X.
- FIN_Y_LO, 10'd80, finish zone lower y bound (inclusive).
- FIN_Y_HI, 10'd160, finish zone upper y bound (inclusive).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  debounced start button, level
- p1_x  in  10  player 1 pos_x
- p1_y  in  10  player 1 pos_y
- p2_x  in  10  player 2 pos_x
- p2_y  in  10  player 2 pos_y
- state  out  3  0 IDLE, 1 CNT3, 2 CNT2, 3 CNT1, 4 RACE, 5 FINISH
- cd_digit  out  2  countdown digit to display: 3/2/1, 0 otherwise
- phys_rst  out  1  one-cycle pulse, synchronous reset for the physics engines
- lap_p1  out  3  completed laps, player 1
- lap_p2  out  3  completed laps, player 2
- winner  out  2  0 none, 1 P1, 2 P2, 3 tie
- race_ticks  out  16  game ticks elapsed in RACE, saturating

Behaviour:
- Reset (rst_n low, async): state=IDLE, cd_digit=0, phys_rst=0, lap_p1=lap_p2=0, winner=0, race_ticks=0, tick counter=0, cd_cnt=0, armed flags=0.
- The start_q edge register resets to 1, so a button held through reset is not seen as a press.
- Game tick: the counter runs 0..TICK_LIMIT-1 in every state. game_tick is high for the single cycle where the counter = TICK_LIMIT-1, after which it wraps to 0.
- start_rise = start & ~start_q. start_q samples start every cycle.
- IDLE + start_rise, on the next clock edge:
  - state <= CNT3, cd_cnt <= 0, phys_rst <= 1 for exactly one cycle.
  - Clear lap_p1, lap_p2, armed flags, winner, race_ticks.
- CNT3/CNT2/CNT1: each game_tick increments cd_cnt. A tick with cd_cnt = COUNT_TICKS-1 advances the state (CNT3→CNT2→CNT1→RACE) and clears cd_cnt.
  - cd_digit is combinational from state: 3, 2, 1; 0 in all other states.
  - start is ignored during the countdown.
- RACE: all position checks are evaluated only on game_tick, using the positions present that cycle.
  - race_ticks += 1, saturating at 16'hFFFF.
  - Per player: if pos_x >= CP_X, set armed.
  - Per player: if armed & pos_x < FIN_X & FIN_Y_LO <= pos_y <= FIN_Y_HI, then lap += 1 and clear armed.
  - CP_X > FIN_X is required, so arm and lap cannot occur on the same tick.
  - Positions are compared unsigned.
- Finish detection uses the post-increment lap values from the same tick:
  - p1_done = (new lap_p1 == LAPS); p2_done likewise.
  - If either is done: state <= FINISH; winner = {p2_done, p1_done}, so 3 means tie on the same tick.
  - race_ticks includes the finishing tick.
- FINISH: laps, winner and race_ticks are frozen; the physics engines halt because state != 4.
  - start_rise → IDLE. Outputs hold their values until the next start from IDLE clears them.
- start_rise in RACE is ignored (no abort).
- Latency: every output is registered except cd_digit. State changes take effect on the clock edge after the qualifying tick or edge.
- Async reset mid-countdown or mid-race returns to IDLE immediately. No phys_rst pulse is generated by reset, because the physics engines share the system reset.
- Unused state encodings 6 and 7 go to IDLE on the next clock.

Test Plan (bench uses CLK_FREQ=600 → TICK_LIMIT=10, COUNT_TICKS=3, LAPS=2):
- Start sequence: rst_n pulse, start held high through reset → stays IDLE. Release, then press → phys_rst high exactly 1 cycle, then state CNT3; reaches RACE after 9 ticks (90 clk), with cd_digit showing 3,3,3,2,2,2,1,1,1.
- Checkpoint required: in RACE, drive p1=(20,120) repeatedly → lap_p1 stays 0. Then (250,120) for one tick, then (20,120) → lap_p1=1.
- Y-window boundary: armed P1 at (20,79) → no lap. At (20,80) → lap. Re-arm, at (20,161) → no lap. At (20,160) → lap.
- Win: P1 completes lap 2 on tick N → same edge state=FINISH, winner=1, race_ticks=N. Further ticks and positions change nothing.
- Tie: both players armed with lap=1, both enter the finish zone on the same tick → winner=3, lap_p1=lap_p2=2.
- Reset/restart: async rst_n low mid-RACE → all outputs reset immediately. Separately, start in FINISH → IDLE with values held; start again → counters cleared and phys_rst pulses. race_ticks saturation checked by forcing 0xFFFE → goes to 0xFFFF then holds.

Source files
------------

// File: rtl/race_controller.sv
// Race sequencer: start countdown, physics reset pulse, checkpoint-validated lap
// counting, race timing and winner selection for a two-player game.
module race_controller #(
    parameter int unsigned CLK_FREQ    = 100_000_000,
    parameter int unsigned COUNT_TICKS = 60,
    parameter int unsigned LAPS        = 3,
    parameter logic [9:0]  CP_X        = 10'd240,
    parameter logic [9:0]  FIN_X       = 10'd40,
    parameter logic [9:0]  FIN_Y_LO    = 10'd80,
    parameter logic [9:0]  FIN_Y_HI    = 10'd160
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [9:0]  p1_x,
    input  logic [9:0]  p1_y,
    input  logic [9:0]  p2_x,
    input  logic [9:0]  p2_y,
    output logic [2:0]  state,
    output logic [1:0]  cd_digit,
    output logic        phys_rst,
    output logic [2:0]  lap_p1,
    output logic [2:0]  lap_p2,
    output logic [1:0]  winner,
    output logic [15:0] race_ticks
);
    localparam int unsigned TICK_LIMIT = CLK_FREQ / 60;
    localparam int unsigned TW = (TICK_LIMIT > 1) ? $clog2(TICK_LIMIT) : 1;
    localparam int unsigned CW = (COUNT_TICKS > 1) ? $clog2(COUNT_TICKS) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_LIMIT - 1);
    localparam logic [CW-1:0] CD_LAST   = CW'(COUNT_TICKS - 1);
    localparam logic [2:0]    LAPS_L    = 3'(LAPS);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CNT3   = 3'd1;
    localparam logic [2:0] S_CNT2   = 3'd2;
    localparam logic [2:0] S_CNT1   = 3'd3;
    localparam logic [2:0] S_RACE   = 3'd4;
    localparam logic [2:0] S_FINISH = 3'd5;

    logic [2:0]    state_q, state_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [CW-1:0] cd_cnt_q, cd_cnt_d;
    logic          start_q;
    logic          phys_rst_q, phys_rst_d;
    logic [2:0]    lap1_q, lap1_d, lap2_q, lap2_d;
    logic          armed1_q, armed1_d, armed2_q, armed2_d;
    logic [1:0]    winner_q, winner_d;
    logic [15:0]   race_ticks_q, race_ticks_d;

    logic game_tick, start_rise, cd_last, cd_state, race_tick;
    logic p1_cp, p1_fin, p2_cp, p2_fin;
    logic p1_lap, p2_lap, p1_done, p2_done, any_done;
    logic [2:0] lap1_inc, lap2_inc;

    assign game_tick  = (tick_q == TICK_LAST);
    assign start_rise = start & ~start_q;
    assign cd_last    = (cd_cnt_q == CD_LAST);
    assign cd_state   = (state_q == S_CNT3) || (state_q == S_CNT2) || (state_q == S_CNT1);
    assign race_tick  = (state_q == S_RACE) && game_tick;

    assign p1_cp  = (p1_x >= CP_X);
    assign p1_fin = (p1_x < FIN_X) && (p1_y >= FIN_Y_LO) && (p1_y <= FIN_Y_HI);
    assign p2_cp  = (p2_x >= CP_X);
    assign p2_fin = (p2_x < FIN_X) && (p2_y >= FIN_Y_LO) && (p2_y <= FIN_Y_HI);

    // A lap only counts after the checkpoint armed it; finish uses the new lap value.
    assign p1_lap   = race_tick && armed1_q && p1_fin;
    assign p2_lap   = race_tick && armed2_q && p2_fin;
    assign lap1_inc = lap1_q + 3'd1;
    assign lap2_inc = lap2_q + 3'd1;
    assign p1_done  = p1_lap && (lap1_inc == LAPS_L);
    assign p2_done  = p2_lap && (lap2_inc == LAPS_L);
    assign any_done = p1_done | p2_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            tick_q       <= '0;
            cd_cnt_q     <= '0;
            start_q      <= 1'b1;
            phys_rst_q   <= 1'b0;
            lap1_q       <= 3'd0;
            lap2_q       <= 3'd0;
            armed1_q     <= 1'b0;
            armed2_q     <= 1'b0;
            winner_q     <= 2'd0;
            race_ticks_q <= 16'd0;
        end else begin
            state_q      <= state_d;
            tick_q       <= tick_d;
            cd_cnt_q     <= cd_cnt_d;
            start_q      <= start;
            phys_rst_q   <= phys_rst_d;
            lap1_q       <= lap1_d;
            lap2_q       <= lap2_d;
            armed1_q     <= armed1_d;
            armed2_q     <= armed2_d;
            winner_q     <= winner_d;
            race_ticks_q <= race_ticks_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start_rise) state_d = S_CNT3;
            S_CNT3:   if (game_tick && cd_last) state_d = S_CNT2;
            S_CNT2:   if (game_tick && cd_last) state_d = S_CNT1;
            S_CNT1:   if (game_tick && cd_last) state_d = S_RACE;
            S_RACE:   if (any_done) state_d = S_FINISH;
            S_FINISH: if (start_rise) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        tick_d       = game_tick ? '0 : tick_q + TW'(1);
        cd_cnt_d     = cd_cnt_q;
        phys_rst_d   = 1'b0;
        lap1_d       = lap1_q;
        lap2_d       = lap2_q;
        armed1_d     = armed1_q;
        armed2_d     = armed2_q;
        winner_d     = winner_q;
        race_ticks_d = race_ticks_q;
        if ((state_q == S_IDLE) && start_rise) begin
            cd_cnt_d     = '0;
            phys_rst_d   = 1'b1;
            lap1_d       = 3'd0;
            lap2_d       = 3'd0;
            armed1_d     = 1'b0;
            armed2_d     = 1'b0;
            winner_d     = 2'd0;
            race_ticks_d = 16'd0;
        end
        if (cd_state && game_tick) begin
            cd_cnt_d = cd_last ? '0 : cd_cnt_q + CW'(1);
        end
        if (race_tick) begin
            if (race_ticks_q != 16'hFFFF) race_ticks_d = race_ticks_q + 16'd1;
            if (p1_lap) begin
                lap1_d   = lap1_inc;
                armed1_d = 1'b0;
            end else if (p1_cp) begin
                armed1_d = 1'b1;
            end
            if (p2_lap) begin
                lap2_d   = lap2_inc;
                armed2_d = 1'b0;
            end else if (p2_cp) begin
                armed2_d = 1'b1;
            end
            if (any_done) winner_d = {p2_done, p1_done};
        end
    end

    always_comb begin
        case (state_q)
            S_CNT3:  cd_digit = 2'd3;
            S_CNT2:  cd_digit = 2'd2;
            S_CNT1:  cd_digit = 2'd1;
            default: cd_digit = 2'd0;
        endcase
    end

    assign state      = state_q;
    assign phys_rst   = phys_rst_q;
    assign lap_p1     = lap1_q;
    assign lap_p2     = lap2_q;
    assign winner     = winner_q;
    assign race_ticks = race_ticks_q;
endmodule
